// File: rtl/plc_semaphore_arbiter.sv
// plc_semaphore_arbiter: round-robin take/release arbiter over a binary-semaphore lock/owner table.
// Latency: a request sampled in cycle N shows ACK, flag and updated table in cycle N+1.
// Backpressure: one grant per cycle; losing cores hold REQ, and the just-acked core is masked for one cycle.
module plc_semaphore_arbiter #(
  parameter int CORES  = 4,
  parameter int SEMS   = 8,
  parameter int SEM_W  = 3,
  parameter int CORE_W = 2
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [CORES-1:0]       CORE_REQ,
  input  logic [CORES-1:0]       CORE_OP,
  input  logic [CORES*SEM_W-1:0] CORE_SEM_ID,
  input  logic [CORES-1:0]       CORE_CLR,
  output logic [CORES-1:0]       CORE_ACK,
  output logic [CORES-1:0]       CORE_SEM_FLAG,
  output logic [SEMS-1:0]        SEM_LOCKED,
  output logic [SEMS*CORE_W-1:0] SEM_OWNER
);

  // Registered state: handshake outputs, round-robin pointer and the lock/owner table.
  logic [CORES-1:0]             r_ack;
  logic [CORES-1:0]             r_flag;
  logic [CORE_W-1:0]            r_rr;
  logic [SEMS-1:0]              r_locked;
  logic [SEMS-1:0][CORE_W-1:0]  r_owner;

  // Combinational arbitration and next-table signals.
  logic [CORES-1:0]             w_elig;
  logic [CORE_W-1:0]            w_idx;
  logic                         w_grant;
  logic [CORE_W-1:0]            w_win;
  logic [CORE_W-1:0]            w_rr_nxt;
  logic                         w_op;
  logic [SEM_W-1:0]             w_id;
  logic                         w_in_range;
  logic                         w_hit_locked;
  logic                         w_hit_own;
  logic                         w_res;
  logic [SEMS-1:0]              w_locked_nxt;
  logic [SEMS-1:0][CORE_W-1:0]  w_owner_nxt;

  // A core that was acked this cycle is still holding its old request, so it is masked out.
  assign w_elig = CORE_REQ & ~CORE_CLR & ~r_ack;

  // Round-robin pick: scan from the highest offset down so the nearest eligible core at/after rr wins.
  always_comb begin
    w_grant = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = CORES - 1; k >= 0; k--) begin
      w_idx = CORE_W'((int'(r_rr) + k) % CORES);
      if (w_elig[w_idx]) begin
        w_grant = 1'b1;
        w_win   = w_idx;
      end
    end
    w_rr_nxt = (w_win == CORE_W'(CORES - 1)) ? '0 : w_win + 1'b1;
  end

  // Fetch the winner's operation and look its semaphore up in the pre-clear table.
  always_comb begin
    w_op         = 1'b0;
    w_id         = '0;
    w_in_range   = 1'b0;
    w_hit_locked = 1'b0;
    w_hit_own    = 1'b0;
    for (int c = 0; c < CORES; c++) begin
      if (w_win == CORE_W'(c)) begin
        w_op = CORE_OP[c];
        w_id = CORE_SEM_ID[c*SEM_W +: SEM_W];
      end
    end
    for (int s = 0; s < SEMS; s++) begin
      if (w_id == SEM_W'(s)) begin
        w_in_range   = 1'b1;
        w_hit_locked = r_locked[s];
        w_hit_own    = (r_owner[s] == w_win);
      end
    end
    // Take succeeds when free or already ours; release succeeds only for the owner.
    w_res = w_grant && w_in_range &&
            (w_op ? (!w_hit_locked || w_hit_own) : (w_hit_locked && w_hit_own));
  end

  // Next table: free semaphores of cleared cores, then apply the granted take/release.
  // The two never touch the same entry because a clearing core is never the winner.
  always_comb begin
    w_locked_nxt = r_locked;
    w_owner_nxt  = r_owner;
    for (int s = 0; s < SEMS; s++) begin
      for (int c = 0; c < CORES; c++) begin
        if (r_locked[s] && CORE_CLR[c] && (r_owner[s] == CORE_W'(c))) begin
          w_locked_nxt[s] = 1'b0;
          w_owner_nxt[s]  = '0;
        end
      end
      if (w_res && (w_id == SEM_W'(s))) begin
        if (w_op) begin
          w_locked_nxt[s] = 1'b1;
          w_owner_nxt[s]  = w_win;
        end else begin
          w_locked_nxt[s] = 1'b0;
          w_owner_nxt[s]  = '0;
        end
      end
    end
  end

  // Commit table, pointer, ACK pulse and per-core result flag on each edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ack    <= '0;
      r_flag   <= '0;
      r_rr     <= '0;
      r_locked <= '0;
      r_owner  <= '0;
    end else begin
      r_locked <= w_locked_nxt;
      r_owner  <= w_owner_nxt;
      if (w_grant) begin
        r_rr <= w_rr_nxt;
      end
      for (int c = 0; c < CORES; c++) begin
        r_ack[c] <= w_grant && (w_win == CORE_W'(c));
        if (CORE_CLR[c]) begin
          r_flag[c] <= 1'b0;
        end else if (w_grant && (w_win == CORE_W'(c))) begin
          r_flag[c] <= w_res;
        end
      end
    end
  end

  assign CORE_ACK      = r_ack;
  assign CORE_SEM_FLAG = r_flag;
  assign SEM_LOCKED    = r_locked;
  assign SEM_OWNER     = r_owner;

endmodule

// File: tb/tb_plc_semaphore_arbiter.sv
// Bench for plc_semaphore_arbiter: directed scenarios plus random traffic,
// every cycle's expected outputs come from a behavioural table model and are
// queued; a monitor pops one entry per clock and compares it against the DUT.
module tb_plc_semaphore_arbiter;
  localparam int CORES  = 4;
  localparam int SEMS   = 8;
  // Index one bit wider than needed so out-of-range IDs (e.g. 9) can be driven.
  localparam int SEM_W  = 4;
  localparam int CORE_W = 2;

  logic                   CLK;
  logic                   RST_N;
  logic [CORES-1:0]       CORE_REQ;
  logic [CORES-1:0]       CORE_OP;
  logic [CORES*SEM_W-1:0] CORE_SEM_ID;
  logic [CORES-1:0]       CORE_CLR;
  logic [CORES-1:0]       CORE_ACK;
  logic [CORES-1:0]       CORE_SEM_FLAG;
  logic [SEMS-1:0]        SEM_LOCKED;
  logic [SEMS*CORE_W-1:0] SEM_OWNER;

  plc_semaphore_arbiter #(
    .CORES(CORES), .SEMS(SEMS), .SEM_W(SEM_W), .CORE_W(CORE_W)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .CORE_REQ(CORE_REQ), .CORE_OP(CORE_OP), .CORE_SEM_ID(CORE_SEM_ID), .CORE_CLR(CORE_CLR),
    .CORE_ACK(CORE_ACK), .CORE_SEM_FLAG(CORE_SEM_FLAG),
    .SEM_LOCKED(SEM_LOCKED), .SEM_OWNER(SEM_OWNER)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [CORES-1:0]       ack;
    logic [CORES-1:0]       flag;
    logic [SEMS-1:0]        locked;
    logic [SEMS*CORE_W-1:0] owner;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  bit m_locked[SEMS];
  int m_owner[SEMS];
  bit m_ack[CORES];
  bit m_flag[CORES];
  int m_rr;

  // Requester state driven onto the ports.
  bit d_req[CORES];
  bit d_op[CORES];
  bit d_clr[CORES];
  bit keep[CORES];
  int d_id[CORES];
  bit rand_mode = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_ports();
    for (int i = 0; i < CORES; i++) begin
      CORE_REQ[i] = d_req[i];
      CORE_OP[i]  = d_op[i];
      CORE_CLR[i] = d_clr[i];
      CORE_SEM_ID[i*SEM_W +: SEM_W] = SEM_W'(d_id[i]);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < SEMS; t++) begin
      m_locked[t] = 1'b0;
      m_owner[t]  = 0;
    end
    for (int c = 0; c < CORES; c++) begin
      m_ack[c]  = 1'b0;
      m_flag[c] = 1'b0;
    end
    m_rr = 0;
  endtask

  // One cycle of the semaphore rules: pick a winner, judge it on the old table,
  // free cleared cores' semaphores, then apply the winner's successful operation.
  task automatic model_cycle();
    int   win;
    int   s;
    bit   res;
    exp_t e;
    win = -1;
    res = 1'b0;
    for (int k = 0; k < CORES; k++) begin
      int c;
      c = (m_rr + k) % CORES;
      if (win < 0 && d_req[c] && !d_clr[c] && !m_ack[c]) win = c;
    end
    if (win >= 0 && d_id[win] < SEMS) begin
      s = d_id[win];
      if (d_op[win]) res = !m_locked[s] || (m_owner[s] == win);
      else           res = m_locked[s] && (m_owner[s] == win);
    end
    for (int t = 0; t < SEMS; t++) begin
      if (m_locked[t] && d_clr[m_owner[t]]) begin
        m_locked[t] = 1'b0;
        m_owner[t]  = 0;
      end
    end
    if (res) begin
      s = d_id[win];
      if (d_op[win]) begin
        m_locked[s] = 1'b1;
        m_owner[s]  = win;
      end else begin
        m_locked[s] = 1'b0;
        m_owner[s]  = 0;
      end
    end
    for (int c = 0; c < CORES; c++) begin
      m_ack[c] = (c == win);
      if (d_clr[c])      m_flag[c] = 1'b0;
      else if (c == win) m_flag[c] = res;
    end
    if (win >= 0) m_rr = (win + 1) % CORES;
    e = '0;
    for (int c = 0; c < CORES; c++) begin
      e.ack[c]  = m_ack[c];
      e.flag[c] = m_flag[c];
    end
    for (int t = 0; t < SEMS; t++) begin
      e.locked[t] = m_locked[t];
      e.owner[t*CORE_W +: CORE_W] = CORE_W'(m_owner[t]);
    end
    sb_q.push_back(e);
  endtask

  // One clock: optional random requests, drive, predict, advance; acked cores drop REQ.
  task automatic step();
    if (rand_mode) begin
      for (int i = 0; i < CORES; i++) begin
        if (!d_req[i] && $urandom_range(0, 2) == 0) begin
          d_req[i] = 1'b1;
          d_op[i]  = 1'($urandom_range(0, 1));
          d_id[i]  = int'($urandom_range(0, SEMS + 1));
        end
        d_clr[i] = ($urandom_range(0, 11) == 0);
      end
    end
    drive_ports();
    model_cycle();
    @(negedge CLK);
    for (int i = 0; i < CORES; i++) begin
      if (m_ack[i] && !keep[i]) d_req[i] = 1'b0;
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic issue(input int c, input bit op, input int id);
    d_req[c] = 1'b1;
    d_op[c]  = op;
    d_id[c]  = id;
  endtask

  // Asserted just after a negedge: whatever request is on the ports is dropped.
  task automatic do_reset();
    drive_ports();
    #1 RST_N = 1'b0;
    #1;
    chk("rst_ack",    64'(CORE_ACK),      64'd0);
    chk("rst_flag",   64'(CORE_SEM_FLAG), 64'd0);
    chk("rst_locked", 64'(SEM_LOCKED),    64'd0);
    chk("rst_owner",  64'(SEM_OWNER),     64'd0);
    for (int i = 0; i < CORES; i++) begin
      d_req[i] = 1'b0;
      d_clr[i] = 1'b0;
      keep[i]  = 1'b0;
    end
    drive_ports();
    model_reset();
    sb_q.delete();
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  // Monitor: one expected entry per clock; with nothing queued no ACK may appear.
  always @(posedge CLK) begin
    #2;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk("ack",    64'(CORE_ACK),      64'(mon_e.ack));
      chk("flag",   64'(CORE_SEM_FLAG), 64'(mon_e.flag));
      chk("locked", 64'(SEM_LOCKED),    64'(mon_e.locked));
      chk("owner",  64'(SEM_OWNER),     64'(mon_e.owner));
    end else begin
      chk("idle_ack", 64'(CORE_ACK), 64'd0);
    end
  end

  initial begin
    RST_N = 1'b0;
    for (int i = 0; i < CORES; i++) begin
      d_req[i] = 1'b0; d_op[i] = 1'b0; d_clr[i] = 1'b0; keep[i] = 1'b0; d_id[i] = 0;
    end
    drive_ports();
    model_reset();
    @(negedge CLK);
    do_reset();

    // Take and release by core 0.
    issue(0, 1'b1, 3); run(2);
    issue(0, 1'b0, 3); run(2);

    // Contention from rr=0: all four take sem 5.
    do_reset();
    for (int c = 0; c < CORES; c++) issue(c, 1'b1, 5);
    run(6);

    // Non-owner release and out-of-range index.
    issue(2, 1'b0, 5); issue(3, 1'b1, 9); run(4);

    // Fairness: cores 1 and 2 hold requests continuously.
    keep[1] = 1'b1; keep[2] = 1'b1;
    issue(1, 1'b1, 6); issue(2, 1'b1, 7); run(8);
    keep[1] = 1'b0; keep[2] = 1'b0; run(3);

    // Clear while core 2 takes a semaphore owned by the clearing core.
    issue(1, 1'b1, 0); run(2);
    issue(1, 1'b1, 4); run(2);
    d_clr[1] = 1'b1; issue(2, 1'b1, 4); step();
    d_clr[1] = 1'b0; run(2);
    issue(2, 1'b1, 4); run(2);

    // Reset mid-request with sem 2 locked by core 1.
    issue(1, 1'b1, 2); run(2);
    issue(1, 1'b1, 6);
    do_reset();
    run(2);

    // Random traffic, then drain outstanding requests.
    rand_mode = 1'b1;
    run(3000);
    rand_mode = 1'b0;
    for (int i = 0; i < CORES; i++) d_clr[i] = 1'b0;
    run(4 * CORES);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
